// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: serializer state encoding and the default word width.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage : cpu_pkg

// File: rtl/word_serializer_if.sv
// Load handshake and serial output bundle for word_serializer.
interface word_serializer_if
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
);

  logic [WIDTH-1:0] dataIn;
  logic             loadValid;
  logic             loadReady;
  logic             abort;
  logic             shiftEn;
  logic             serialOut;
  logic             serialValid;
  logic             serialLast;
  logic             busy;

  modport master (
    output dataIn, loadValid, abort, shiftEn,
    input  loadReady, serialOut, serialValid, serialLast, busy
  );

  modport slave (
    input  dataIn, loadValid, abort, shiftEn,
    output loadReady, serialOut, serialValid, serialLast, busy
  );

endinterface : word_serializer_if

// File: rtl/word_serializer.sv
// Parallel-in serial-out unload register: accepts a word over valid/ready and
// emits it one bit per shiftEn cycle with valid/last framing.
module word_serializer
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH     = WORD_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic              CLK,
  input logic              RSTn,
  word_serializer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             load_ok;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    load_ok = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load_ok = 1'b1;
        if (bus.loadValid) begin
          shreg_d = bus.dataIn;
          cnt_d   = CW'(WIDTH - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end else if (bus.shiftEn) begin
          if (cnt_zero) begin
            // Last bit consumed: reload in the same cycle for a bubble-free stream.
            load_ok = 1'b1;
            if (bus.loadValid) begin
              shreg_d = bus.dataIn;
              cnt_d   = CW'(WIDTH - 1);
            end else begin
              state_d = ST_IDLE;
              shreg_d = '0;
            end
          end else begin
            if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Gated by RSTn so no word can be offered as accepted while reset is held.
  assign bus.loadReady   = load_ok & RSTn;
  assign bus.serialValid = (state_q == ST_SHIFT);
  assign bus.busy        = (state_q == ST_SHIFT);
  assign bus.serialLast  = (state_q == ST_SHIFT) & cnt_zero;
  assign bus.serialOut   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule : word_serializer

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: MSB-first and LSB-first instances share stimulus
// and are compared each cycle against a bit-queue model.
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic        lv, ab, se;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  word_serializer_if #(.WIDTH(32)) mif ();
  word_serializer_if #(.WIDTH(32)) lif ();

  assign mif.dataIn = data;  assign mif.loadValid = lv;
  assign mif.abort  = ab;    assign mif.shiftEn   = se;
  assign lif.dataIn = data;  assign lif.loadValid = lv;
  assign lif.abort  = ab;    assign lif.shiftEn   = se;

  word_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_m (.CLK(clk), .RSTn(rst_n), .bus(mif.slave));
  word_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_l (.CLK(clk), .RSTn(rst_n), .bus(lif.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance holds the remaining bits of the word in flight, in emission order.
  bit qm[$];
  bit ql[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() != 0) begin
        if (ab) qm.delete();
        else if (se) begin
          void'(qm.pop_front());
          if (qm.size() == 0 && lv) for (int i = 31; i >= 0; i--) qm.push_back(data[i]);
        end
      end else if (lv) for (int i = 31; i >= 0; i--) qm.push_back(data[i]);
      if (ql.size() != 0) begin
        if (ab) ql.delete();
        else if (se) begin
          void'(ql.pop_front());
          if (ql.size() == 0 && lv) for (int i = 0; i < 32; i++) ql.push_back(data[i]);
        end
      end else if (lv) for (int i = 0; i < 32; i++) ql.push_back(data[i]);
    end
  end

  function automatic logic [4:0] expect_outs(input int unsigned sz, input bit head);
    logic v;
    v = (sz != 0);
    return {rst_n & (!v | (sz == 1 && se && !ab)), v, v & head, sz == 1, v};
  endfunction

  // Per-cycle comparison plus collection of the bits each DUT actually hands over.
  logic [63:0] acc_m = '0;
  logic [31:0] acc_l = '0;
  int unsigned got_m = 0, got_l = 0, last_idx_m = 0, last_idx_l = 0, last_n_m = 0;

  always @(negedge clk) begin
    chk("model_msb", {59'b0, mif.loadReady, mif.serialValid, mif.serialOut, mif.serialLast, mif.busy},
        {59'b0, expect_outs(qm.size(), qm.size() != 0 ? qm[0] : 1'b0)});
    chk("model_lsb", {59'b0, lif.loadReady, lif.serialValid, lif.serialOut, lif.serialLast, lif.busy},
        {59'b0, expect_outs(ql.size(), ql.size() != 0 ? ql[0] : 1'b0)});
    if (rst_n && se && !ab && mif.serialValid) begin
      acc_m = {acc_m[62:0], mif.serialOut};
      if (mif.serialLast) begin last_idx_m = got_m; last_n_m++; end
      got_m++;
    end
    if (rst_n && se && !ab && lif.serialValid) begin
      acc_l = {lif.serialOut, acc_l[31:1]};
      if (lif.serialLast) last_idx_l = got_l;
      got_l++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    data = w; lv = 1'b1; se = 1'b0;
    step();
    lv = 1'b0;
  endtask

  int unsigned base, base_l, lbase, en, rdy, vld;

  initial begin
    rst_n = 1'b0; data = '0; lv = 1'b0; ab = 1'b0; se = 1'b0;
    step(); step();
    chk("reset_ready", {63'b0, mif.loadReady}, 64'd0);
    chk("reset_valid", {63'b0, mif.serialValid}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", {63'b0, mif.loadReady}, 64'd1);

    // Reset mid-word
    load(32'hA5A5_0000);
    se = 1'b1;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {63'b0, mif.serialValid}, 64'd0);
    chk("rst_mid_ready", {63'b0, mif.loadReady}, 64'd0);
    step(); step();
    #1 rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", {63'b0, mif.loadReady}, 64'd1);
    repeat (3) begin
      step();
      chk("rst_rel_busy", {62'b0, mif.busy, mif.serialValid}, 64'd0);
    end
    se = 1'b0;

    // MSB-first framing
    base = got_m; base_l = got_l; lbase = last_n_m;
    load(32'h8000_0001);
    chk("msb_first_bit", {63'b0, mif.serialOut}, 64'd1);
    se = 1'b1;
    repeat (32) step();
    se = 1'b0;
    chk("msb_word", {32'b0, acc_m[31:0]}, 64'h8000_0001);
    chk("msb_count", 64'(got_m - base), 64'd32);
    chk("msb_last_pos", 64'(last_idx_m - base), 64'd31);
    chk("msb_last_once", 64'(last_n_m - lbase), 64'd1);
    chk("msb_idle_33", {63'b0, mif.busy}, 64'd0);
    chk("lsb_sym_word", {32'b0, acc_l}, 64'h8000_0001);
    chk("lsb_sym_count", 64'(got_l - base_l), 64'd32);

    // Stall pattern 1,0,0,1,0,0,...
    base = got_m; en = 0;
    load(32'hF0F0_F0F0);
    for (int k = 0; k < 200 && mif.busy; k++) begin
      se = (k % 3 == 0);
      if (se && mif.serialValid) en++;
      step();
    end
    se = 1'b0;
    chk("stall_done", {63'b0, mif.busy}, 64'd0);
    chk("stall_en_cycles", 64'(en), 64'd32);
    chk("stall_word", {32'b0, acc_m[31:0]}, 64'hF0F0_F0F0);

    // Back-to-back, no bubble
    base = got_m; rdy = 0; vld = 0;
    load(32'hFFFF_FFFF);
    data = '0; lv = 1'b1; se = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < 32 && mif.loadReady) rdy++;
      if (mif.serialValid) vld++;
      step();
      if (i == 31) lv = 1'b0;
    end
    se = 1'b0;
    chk("b2b_stream", acc_m, 64'hFFFF_FFFF_0000_0000);
    chk("b2b_count", 64'(got_m - base), 64'd64);
    chk("b2b_ready_pulse", 64'(rdy), 64'd1);
    chk("b2b_valid", 64'(vld), 64'd64);
    chk("b2b_idle", {63'b0, mif.busy}, 64'd0);

    // Abort beats a simultaneous load
    base = got_m;
    load(32'h1234_5678);
    se = 1'b1;
    repeat (10) step();
    ab = 1'b1; lv = 1'b1; data = 32'hDEAD_BEEF;
    #1;
    chk("abort_ready", {63'b0, mif.loadReady}, 64'd0);
    step();
    ab = 1'b0; lv = 1'b0; se = 1'b0;
    #1;
    chk("abort_idle", {62'b0, mif.busy, mif.serialValid}, 64'd0);
    chk("abort_bits", {54'b0, acc_m[9:0]}, 64'h048);
    chk("abort_count", 64'(got_m - base), 64'd10);
    load(32'h8000_0000);
    chk("abort_restart", {63'b0, mif.serialOut}, 64'd1);
    se = 1'b1;
    repeat (32) step();
    se = 1'b0;
    chk("abort_next_word", {32'b0, acc_m[31:0]}, 64'h8000_0000);

    // LSB-first
    base_l = got_l;
    load(32'h0000_0003);
    chk("lsb_first_bit", {63'b0, lif.serialOut}, 64'd1);
    se = 1'b1;
    repeat (32) step();
    se = 1'b0;
    chk("lsb_word", {32'b0, acc_l}, 64'h3);
    chk("lsb_last_pos", 64'(last_idx_l - base_l), 64'd31);
    chk("lsb_msb_view", {32'b0, acc_m[31:0]}, 64'h3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_word_serializer
